// File: rtl/grf_pkg.sv
// Shared encodings for the general register file: FunSel codes, read-select codes
// and the default datapath width.
package grf_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  typedef logic [2:0] fun_sel_t;
  typedef logic [2:0] reg_sel_t;

  localparam fun_sel_t FS_DEC          = 3'b000;
  localparam fun_sel_t FS_INC          = 3'b001;
  localparam fun_sel_t FS_LOAD         = 3'b010;
  localparam fun_sel_t FS_CLR          = 3'b011;
  localparam fun_sel_t FS_LOADLO_CLRHI = 3'b100;
  localparam fun_sel_t FS_LOADLO       = 3'b101;
  localparam fun_sel_t FS_LOADHI       = 3'b110;
  localparam fun_sel_t FS_SEXT         = 3'b111;

  localparam reg_sel_t SEL_R1 = 3'd0;
  localparam reg_sel_t SEL_R2 = 3'd1;
  localparam reg_sel_t SEL_R3 = 3'd2;
  localparam reg_sel_t SEL_R4 = 3'd3;
  localparam reg_sel_t SEL_S1 = 3'd4;
  localparam reg_sel_t SEL_S2 = 3'd5;
  localparam reg_sel_t SEL_S3 = 3'd6;
  localparam reg_sel_t SEL_S4 = 3'd7;

endpackage

// File: rtl/general_register_file_if.sv
// Operand bus of the register file: write data, function/enable controls and the
// two read ports feeding the ALU.
interface general_register_file_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] I;
    logic [2:0]            FunSel;
    logic [3:0]            RegSel;
    logic [3:0]            ScrSel;
    logic [2:0]            OutASel;
    logic [2:0]            OutBSel;
    logic [DATA_WIDTH-1:0] OutA;
    logic [DATA_WIDTH-1:0] OutB;

    modport master (
        output I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        input  OutA, OutB
    );

    modport slave (
        input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        output OutA, OutB
    );
endinterface

// File: rtl/grf_register.sv
// One register of the file: applies FunSel to its own value on the rising edge when
// enabled; asynchronously cleared to RESET_VALUE.
module grf_register
    import grf_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  E,
    input  fun_sel_t              FunSel,
    input  logic [DATA_WIDTH-1:0] I,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] q_d;

    // Byte forms assume the low byte of I is the operand; carries are dropped.
    always_comb begin
        q_d = Q;
        case (FunSel)
            FS_DEC:          q_d = Q - DATA_WIDTH'(1);
            FS_INC:          q_d = Q + DATA_WIDTH'(1);
            FS_LOAD:         q_d = I;
            FS_CLR:          q_d = '0;
            FS_LOADLO_CLRHI: q_d = {{(DATA_WIDTH-8){1'b0}}, I[7:0]};
            FS_LOADLO:       q_d = {Q[DATA_WIDTH-1:8], I[7:0]};
            FS_LOADHI:       q_d = {I[7:0], Q[DATA_WIDTH-9:0]};
            FS_SEXT:         q_d = {{(DATA_WIDTH-8){I[7]}}, I[7:0]};
            default:         q_d = Q;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Q <= RESET_VALUE;
        end else if (E) begin
            Q <= q_d;
        end
    end

endmodule

// File: rtl/general_register_file.sv
// Four general and four scratch registers with two combinational read ports.
// Optional write-through read bypass for FunSel load: define GRF_BYPASS_EN.
module general_register_file
    import grf_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    general_register_file_if.slave bus
);

    // Index order matches the read-select encoding: R1..R4 then S1..S4.
    logic [7:0]            en;
    logic [DATA_WIDTH-1:0] q [8];

    assign en = {bus.ScrSel, bus.RegSel};

    for (genvar k = 0; k < 8; k++) begin : g_reg
        grf_register #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_reg (
            .Clock  (Clock),
            .ResetN (ResetN),
            .E      (en[k]),
            .FunSel (bus.FunSel),
            .I      (bus.I),
            .Q      (q[k])
        );
    end

`ifdef GRF_BYPASS_EN
    logic bypass_a;
    logic bypass_b;

    // Reset gating keeps both ports at RESET_VALUE while ResetN is low.
    assign bypass_a = ResetN && en[bus.OutASel] && (bus.FunSel == FS_LOAD);
    assign bypass_b = ResetN && en[bus.OutBSel] && (bus.FunSel == FS_LOAD);

    always_comb begin
        bus.OutA = bypass_a ? bus.I : q[bus.OutASel];
        bus.OutB = bypass_b ? bus.I : q[bus.OutBSel];
    end
`else
    always_comb begin
        bus.OutA = q[bus.OutASel];
        bus.OutB = q[bus.OutBSel];
    end
`endif

endmodule
